// File: rtl/asic_lock_pkg.sv
// Shared types and helpers for the ASIC feature-lock sequence detector.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package asic_lock_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_RUN} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_LOCK, PEND_UNLOCK} pend_t;

  localparam logic [7:0] DEF_SEED    = 8'hFF;
  localparam logic [7:0] DEF_TAPS_HI = 8'h90;
  localparam logic [7:0] DEF_TAPS_LO = 8'h03;

  // Widest LFSR the helper below handles; callers zero-extend into it.
  localparam int LFSR_MAX_W = 32;

  // Shift right by one, then overwrite the top bit and the middle bit
  // (w/2-1) with the XOR-reduced tap masks of the current value.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] q,
    input logic [LFSR_MAX_W-1:0] taps_hi,
    input logic [LFSR_MAX_W-1:0] taps_lo,
    input int unsigned           w
  );
    logic [LFSR_MAX_W-1:0] n;
    logic [4:0]            hi_idx;
    logic [4:0]            lo_idx;
    hi_idx     = 5'(w - 1);
    lo_idx     = 5'((w / 2) - 1);
    n          = q >> 1;
    n[hi_idx]  = ^(q & taps_hi);
    n[lo_idx]  = ^(q & taps_lo);
    return n;
  endfunction

endpackage

// File: rtl/asic_lock_seq_lfsr.sv
// LFSR register plus sequence position counter for the lock detector.
// Latency: value/pos update on the clk edge after load_seed or advance.
// Backpressure: none; load_seed has priority over advance.
module asic_lock_lfsr #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] SEED    = 8'hFF,
  parameter logic [DATA_W-1:0] TAPS_HI = 8'h90,
  parameter logic [DATA_W-1:0] TAPS_LO = 8'h03,
  parameter int                SEQ_LEN = 15,
  parameter int                POS_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_seed,
  input  logic              advance,
  output logic [DATA_W-1:0] value,
  output logic [POS_W-1:0]  pos,
  output logic              wrap
);
  import asic_lock_pkg::*;

  logic [DATA_W-1:0] nxt;

  assign nxt  = DATA_W'(lfsr_next(LFSR_MAX_W'(value), LFSR_MAX_W'(TAPS_HI),
                                  LFSR_MAX_W'(TAPS_LO), DATA_W));
  // Last position of the sequence: the next match returns to the seed.
  assign wrap = (pos == POS_W'(SEQ_LEN - 1));

  // Seed reload or single-step advance of value and position together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
      pos   <= '0;
    end else if (load_seed) begin
      value <= SEED;
      pos   <= '0;
    end else if (advance) begin
      value <= nxt;
      pos   <= pos + POS_W'(1);
    end
  end

endmodule

// File: rtl/asic_lock_seq.sv
// Feature-lock sequence detector on the Z80 lock port; sets/clears enf.
// Latency: outputs register on the clk edge that accepts a write; pulses 1 clk.
// Backpressure: none; one accept per I/O cycle (rising edge of qualified strobe).
// Option: ASIC_LOCK_REDUCED_COMPARE_EN compares only the upper data half.
module asic_lock_seq
  import asic_lock_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] SEED       = DEF_SEED,
  parameter logic [DATA_W-1:0] TAPS_HI    = DEF_TAPS_HI,
  parameter logic [DATA_W-1:0] TAPS_LO    = DEF_TAPS_LO,
  parameter int                SEQ_LEN    = 15,
  parameter int                LOCK_POS   = 12,
  parameter int                UNLOCK_POS = 13
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ioreq_b,
  input  logic                       wr_b,
  input  logic                       io_cs,
  input  logic [DATA_W-1:0]          data,
  output logic                       enf,
  output logic                       lock_evt,
  output logic                       unlock_evt,
  output logic                       synced,
  output logic [$clog2(SEQ_LEN)-1:0] seq_pos
);
  localparam int POS_W = $clog2(SEQ_LEN);

  state_t            state;
  pend_t             pend;
  logic              stb;
  logic              stb_q;
  logic              acc;
  logic              data_zero;
  logic              match;
  logic              load_seed;
  logic              advance;
  logic              lfsr_wrap;
  logic [DATA_W-1:0] lfsr_q;
  logic [POS_W-1:0]  pos;

  assign stb       = ~ioreq_b & ~wr_b & io_cs;
  assign acc       = stb & ~stb_q;
  assign data_zero = (data == '0);
  assign seq_pos   = pos;

`ifdef ASIC_LOCK_REDUCED_COMPARE_EN
  assign match = (data[DATA_W-1:DATA_W/2] == lfsr_q[DATA_W-1:DATA_W/2]);
`else
  assign match = (data == lfsr_q);
`endif

  asic_lock_lfsr #(
    .DATA_W  (DATA_W),
    .SEED    (SEED),
    .TAPS_HI (TAPS_HI),
    .TAPS_LO (TAPS_LO),
    .SEQ_LEN (SEQ_LEN),
    .POS_W   (POS_W)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .load_seed (load_seed),
    .advance   (advance),
    .value     (lfsr_q),
    .pos       (pos),
    .wrap      (lfsr_wrap)
  );

  // Decide how an accepted write moves the LFSR/position pair.
  always_comb begin
    load_seed = 1'b0;
    advance   = 1'b0;
    if (acc) begin
      case (state)
        ST_PRE: load_seed = data_zero;
        ST_RUN: begin
          if (match) begin
            load_seed = lfsr_wrap;
            advance   = ~lfsr_wrap;
          end else if (data_zero && (pos != '0)) begin
            load_seed = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Remember the strobe so a long I/O cycle is accepted only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stb_q <= 1'b0;
    else       stb_q <= stb;
  end

  // Sequence FSM, pending-action apply and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pend       <= PEND_NONE;
      enf        <= 1'b0;
      lock_evt   <= 1'b0;
      unlock_evt <= 1'b0;
      synced     <= 1'b0;
    end else begin
      lock_evt   <= 1'b0;
      unlock_evt <= 1'b0;
      if (acc) begin
        // Whatever was armed by the previous write lands now, regardless
        // of whether this write matches.
        case (pend)
          PEND_UNLOCK: begin
            enf        <= 1'b1;
            unlock_evt <= 1'b1;
          end
          PEND_LOCK: begin
            enf      <= 1'b0;
            lock_evt <= 1'b1;
          end
          default: ;
        endcase
        pend <= PEND_NONE;

        case (state)
          ST_IDLE: if (!data_zero) state <= ST_PRE;
          ST_PRE: begin
            if (data_zero) begin
              state  <= ST_RUN;
              synced <= 1'b1;
            end
          end
          ST_RUN: begin
            if (match) begin
              // Unlock checked first so it wins if both positions coincide.
              if (pos == POS_W'(UNLOCK_POS))    pend <= PEND_UNLOCK;
              else if (pos == POS_W'(LOCK_POS)) pend <= PEND_LOCK;
            end else if (!data_zero) begin
              state  <= ST_PRE;
              synced <= 1'b0;
            end else if (pos == '0) begin
              state  <= ST_IDLE;
              synced <= 1'b0;
            end
          end
          default: begin
            state  <= ST_IDLE;
            synced <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
